// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stall-vector constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  // Bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
  typedef logic [5:0] stall_t;

  typedef enum logic [1:0] {
    StRun,
    StPend,
    StFlush
  } ctrl_state_t;

  localparam stall_t StallNone = 6'b000000;
  localparam stall_t StallIf   = 6'b000011;
  localparam stall_t StallId   = 6'b000111;
  localparam stall_t StallEx   = 6'b001111;
  localparam stall_t StallMem  = 6'b011111;
  localparam stall_t StallAll  = 6'b111111;

endpackage

// File: rtl/stall_prio_enc.sv
// Priority encoder: the latest stage requesting a stall holds itself and every earlier stage.
module stall_prio_enc
  import pipe_ctrl_pkg::*;
(
  input  logic       i_req_if,
  input  logic       i_req_id,
  input  logic       i_req_ex,
  input  logic       i_req_mem,
  output logic [5:0] o_stall
);

  always_comb begin
    o_stall = StallNone;
    if (i_req_mem) begin
      o_stall = StallMem;
    end else if (i_req_ex) begin
      o_stall = StallEx;
    end else if (i_req_id) begin
      o_stall = StallId;
    end else if (i_req_if) begin
      o_stall = StallIf;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller; defers exception flushes behind busy bus transactions.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned PEND_MAX = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_req,
  input  logic [31:0] excp_target,
  input  logic        bus_busy,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_abort
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  localparam bit             AbortEn  = (PEND_MAX != 0);
  localparam logic [CNT_W-1:0] PendLast = CNT_W'(PEND_MAX - 1);

  ctrl_state_t      r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [31:0]      r_tgt, w_tgt_d;
  logic [5:0]       w_enc_stall;

  stall_prio_enc u_stall_prio_enc (
    .i_req_if (stallreq_if),
    .i_req_id (stallreq_id),
    .i_req_ex (stallreq_ex),
    .i_req_mem(stallreq_mem),
    .o_stall  (w_enc_stall)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_tgt_d   = r_tgt;
    stall     = StallNone;
    flush     = 1'b0;
    new_pc    = 32'h0;
    bus_abort = 1'b0;
    // Outputs are forced quiet while reset is asserted.
    if (!rst) begin
      unique case (r_state)
        StRun: begin
          stall = w_enc_stall;
          if (excp_req) begin
            w_tgt_d   = excp_target;
            w_cnt_d   = '0;
            w_state_d = bus_busy ? StPend : StFlush;
          end
        end
        StPend: begin
          stall   = StallAll;
          w_cnt_d = r_cnt + CNT_W'(1);
          if (!bus_busy) begin
            w_state_d = StFlush;
          end else if (AbortEn && (r_cnt == PendLast)) begin
            bus_abort = 1'b1;
            w_state_d = StFlush;
          end
        end
        StFlush: begin
          flush     = 1'b1;
          new_pc    = r_tgt;
          w_state_d = StRun;
        end
        default: w_state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StRun;
      r_cnt   <= '0;
      r_tgt   <= 32'h0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_tgt   <= w_tgt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  // Both counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 32'h0;
      r_flush_count  <= 16'h0;
    end else begin
      if (stall[0] && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (flush && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-level reference model queues expected outputs,
// a negedge monitor pops and compares them.
module tb_pipe_ctrl;

  localparam int unsigned PendMax = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        sr_if, sr_id, sr_ex, sr_mem;
  logic        excp_req;
  logic [31:0] excp_target;
  logic        bus_busy;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        bus_abort;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  longint unsigned m_stall_cycles;
  longint unsigned m_flush_count;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(
    .PEND_MAX(PendMax),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_if (sr_if),
    .stallreq_id (sr_id),
    .stallreq_ex (sr_ex),
    .stallreq_mem(sr_mem),
    .excp_req    (excp_req),
    .excp_target (excp_target),
    .bus_busy    (bus_busy),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .bus_abort   (bus_abort)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        abort;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: an exception either flushes next cycle, or waits (counting cycles)
  // for the bus and then flushes.
  bit          m_flush;
  bit          m_wait;
  int unsigned m_waited;
  logic [31:0] m_tgt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_cycle(input bit r, input logic [3:0] req, input bit ex,
                             input logic [31:0] tg, input bit busy);
    exp_t e;
    int   hi;
    e = '0;
    if (!r) begin
      if (m_flush) begin
        e.flush  = 1'b1;
        e.new_pc = m_tgt;
      end else if (m_wait) begin
        e.stall = 6'h3F;
        e.abort = busy && (m_waited + 1 == PendMax);
      end else begin
        hi = -1;
        for (int k = 0; k < 4; k++) if (req[k]) hi = k;
        if (hi >= 0) e.stall = 6'((1 << (hi + 2)) - 1);
      end
    end
    exp_q.push_back(e);
`ifdef PIPE_CTRL_PERF_EN
    if (r) begin
      m_stall_cycles = 0;
      m_flush_count  = 0;
    end else begin
      if (e.stall[0] && m_stall_cycles < 64'hFFFF_FFFF) m_stall_cycles++;
      if (e.flush && m_flush_count < 64'hFFFF) m_flush_count++;
    end
`endif
    if (r) begin
      m_flush  = 0;
      m_wait   = 0;
      m_waited = 0;
      m_tgt    = 32'h0;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (m_wait) begin
      m_waited++;
      if (!busy || m_waited == PendMax) begin
        m_wait  = 0;
        m_flush = 1;
      end
    end else if (ex) begin
      m_tgt = tg;
      if (busy) begin
        m_wait   = 1;
        m_waited = 0;
      end else begin
        m_flush = 1;
      end
    end
  endtask

  task automatic step(input bit r, input logic [3:0] req, input bit ex,
                      input logic [31:0] tg, input bit busy);
    @(posedge clk);
    #1;
    rst         = r;
    {sr_mem, sr_ex, sr_id, sr_if} = req;
    excp_req    = ex;
    excp_target = tg;
    bus_busy    = busy;
    model_cycle(r, req, ex, tg, busy);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall", 32'(stall), 32'(e.stall));
        check("flush", 32'(flush), 32'(e.flush));
        check("new_pc", new_pc, e.new_pc);
        check("bus_abort", 32'(bus_abort), 32'(e.abort));
      end
    end
  end

  initial begin : stimulus
    bit busy;
    rst = 1'b1; {sr_mem, sr_ex, sr_id, sr_if} = 4'b0;
    excp_req = 1'b0; excp_target = 32'h0; bus_busy = 1'b0;
    m_flush = 0; m_wait = 0; m_waited = 0; m_tgt = 32'h0;
`ifdef PIPE_CTRL_PERF_EN
    m_stall_cycles = 0; m_flush_count = 0;
`endif
    step(1, 4'b1111, 1, 32'hDEAD_BEEF, 1);
    step(1, 4'b0000, 0, 32'h0, 0);
    // Priority encoding
    step(0, 4'b0010, 0, 32'h0, 0);
    step(0, 4'b0110, 0, 32'h0, 0);
    step(0, 4'b1110, 0, 32'h0, 0);
    step(0, 4'b0001, 0, 32'h0, 0);
    step(0, 4'b0000, 0, 32'h0, 0);
    // Exception with idle bus; flush overrides requests
    step(0, 4'b0100, 1, 32'hBFC0_0380, 0);
    step(0, 4'b1111, 1, 32'h1111_1111, 0);
    step(0, 4'b0000, 0, 32'h0, 0);
    // Exception deferred by a 4-cycle bus transaction
    step(0, 4'b0000, 1, 32'h8000_0180, 1);
    repeat (3) step(0, 4'b0001, 1, 32'h1234_5678, 1);
    step(0, 4'b0000, 0, 32'h0, 0);
    step(0, 4'b0000, 0, 32'h0, 0);
    step(0, 4'b0000, 0, 32'h0, 0);
    // Bus stuck busy: forced abort after PendMax waiting cycles
    step(0, 4'b0000, 1, 32'h8000_0200, 1);
    repeat (10) step(0, 4'b0000, 0, 32'h0, 1);
    step(0, 4'b0000, 0, 32'h0, 0);
    // Reset while pending drops the exception
    step(0, 4'b0000, 1, 32'hA5A5_0000, 1);
    step(0, 4'b0000, 0, 32'h0, 1);
    step(1, 4'b0000, 0, 32'h0, 1);
    repeat (4) step(0, 4'b0000, 0, 32'h0, 0);
    // Randomized traffic
    busy = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) busy = ~busy;
      step($urandom_range(63) == 0, 4'($urandom), $urandom_range(5) == 0, $urandom, busy);
    end
    repeat (3) step(0, 4'b0000, 0, 32'h0, 0);
`ifdef PIPE_CTRL_PERF_EN
    @(posedge clk);
    #1;
    check("stall_cycles", stall_cycles, 32'(m_stall_cycles));
    check("flush_count", 32'(flush_count), 32'(m_flush_count));
`endif
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
